// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Deserialises LSB-first frames from one serial line: start bit,
//   DATA_WIDTH data bits, optional parity bit, STOP_BITS stop bits.
//   Each bit lasts CLKS_PER_BIT clocks and is sampled once, mid-bit.
//   A start bit that has gone away by mid-bit is rejected as a glitch.
//   A finished frame goes into a one-entry output register with
//   parity/framing status.
//
// Ports
//   clk        in   system clock
//   arst_n     in   asynchronous active-low reset
//   in         in   serial line, already synchronous to clk
//   out_data   out  received data, bit 0 = first bit on the line
//   out_valid  out  output register holds a frame
//   out_ready  in   consumer takes the frame
//   parity_err out  parity mismatch of the held frame (0 when no parity)
//   frame_err  out  a stop bit of the held frame was not STOP_LEVEL
//   overflow   out  one-cycle pulse: a finished frame was lost (register full)
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: the frame in the output register is transferred on every clock
// edge where out_valid && out_ready. While out_valid is high and out_ready is
// low, out_data/parity_err/frame_err do not change.
module serial_frame_receiver #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int START_LEVEL  = 1,
  parameter int STOP_LEVEL   = 1,
  parameter int ERR_DROP     = 0
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overflow,
  output logic [2:0]            dbg_state
);

  localparam int   CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int   IW      = $clog2(DATA_WIDTH + 1);
  localparam int   HALF    = CLKS_PER_BIT / 2;
  localparam logic L_START = 1'(START_LEVEL);
  localparam logic L_STOP  = 1'(STOP_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_bit_cnt;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_err;
  logic                  r_frm_err;

  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_pe;
  logic                  r_out_fe;
  logic                  r_ovf;

  state_t                w_nstate;
  logic [CW-1:0]         w_nbit;
  logic [IW-1:0]         w_nidx;
  logic [DATA_WIDTH-1:0] w_nshift;
  logic                  w_npe;
  logic                  w_nfe;
  logic                  w_done;
  logic                  w_sample;
  logic                  w_last;
  logic [CW-1:0]         w_bit_inc;
  logic                  w_par_x;
  logic                  w_accept;
  logic                  w_keep;

  // With CLKS_PER_BIT==1 the counter is stuck at 0, so every cycle is both
  // the sample cycle and the last cycle of its bit.
  assign w_sample  = (r_bit_cnt == CW'(HALF));
  assign w_last    = (r_bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_bit_inc = w_last ? '0 : r_bit_cnt + CW'(1);
  assign w_par_x   = (^r_shift) ^ in;

  always_comb begin
    w_nstate = r_state;
    w_nbit   = r_bit_cnt;
    w_nidx   = r_idx;
    w_nshift = r_shift;
    w_npe    = r_par_err;
    w_nfe    = r_frm_err;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nbit = '0;
        w_nidx = '0;
        w_npe  = 1'b0;
        w_nfe  = 1'b0;
        // The detecting cycle is clock 0 of the start bit.
        if (in == L_START) begin
          if (CLKS_PER_BIT == 1) begin
            w_nstate = S_DATA;
          end else begin
            w_nstate = S_START;
            w_nbit   = CW'(1);
          end
        end
      end
      S_START: begin
        w_nbit = w_bit_inc;
        if (w_sample && (in != L_START)) begin
          w_nstate = S_IDLE;
          w_nbit   = '0;
        end else if (w_last) begin
          w_nstate = S_DATA;
        end
      end
      S_DATA: begin
        w_nbit = w_bit_inc;
        // Shift in at the MSB end so the first bit ends up in bit 0.
        if (w_sample) begin
          w_nshift = (r_shift >> 1) | (DATA_WIDTH'(in) << (DATA_WIDTH - 1));
        end
        if (w_last) begin
          if (r_idx == IW'(DATA_WIDTH - 1)) begin
            w_nidx   = '0;
            w_nstate = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end else begin
            w_nidx = r_idx + IW'(1);
          end
        end
      end
      S_PARITY: begin
        w_nbit = w_bit_inc;
        if (w_sample) begin
          w_npe = (PARITY_MODE == 2) ? ~w_par_x : w_par_x;
        end
        if (w_last) begin
          w_nidx   = '0;
          w_nstate = S_STOP;
        end
      end
      S_STOP: begin
        w_nbit = w_bit_inc;
        if (w_sample && (in != L_STOP)) begin
          w_nfe = 1'b1;
        end
        if (w_last) begin
          if (r_idx == IW'(STOP_BITS - 1)) begin
            w_done   = 1'b1;
            w_nidx   = '0;
            w_nstate = S_IDLE;
          end else begin
            w_nidx = r_idx + IW'(1);
          end
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_nbit   = '0;
        w_nidx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_bit_cnt <= w_nbit;
      r_idx     <= w_nidx;
      r_shift   <= w_nshift;
      r_par_err <= w_npe;
      r_frm_err <= w_nfe;
    end
  end

  // On the completion cycle w_nfe already includes a stop sample taken in
  // that same cycle, so the loaded flags are final.
  assign w_accept = r_out_valid && out_ready;
  assign w_keep   = !((ERR_DROP != 0) && (w_npe || w_nfe));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_pe    <= 1'b0;
      r_out_fe    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_done && w_keep) begin
        // A register emptied by this cycle's accept can take the new frame.
        if (!r_out_valid || w_accept) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_nshift;
          r_out_pe    <= w_npe;
          r_out_fe    <= w_nfe;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign parity_err = r_out_pe;
  assign frame_err  = r_out_fe;
  assign overflow   = r_ovf;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver. Four instances with different parameter
// sets share clock and reset; each has its own line and ready input:
//   0: defaults   1: ERR_DROP=1   2: CLKS_PER_BIT=16   3: STOP_BITS=2, no parity
// The frame-level model takes each finished frame from the driver (data and
// the flags implied by the bits sent) and predicts the output register.
module tb_serial_frame_receiver;

  localparam int N = 4;
  localparam int P_CLKS  [N] = '{1, 1, 16, 1};
  localparam int P_PMODE [N] = '{1, 1, 1, 0};
  localparam int P_STOPS [N] = '{1, 1, 1, 2};
  localparam int P_DROP  [N] = '{0, 1, 0, 0};

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic arst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUTs
  logic [N-1:0] line, rdy, vld, pe, fe, ovf;
  logic [7:0]   dout [N];
  logic [2:0]   dbg  [N];

  serial_frame_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(P_CLKS[0]), .PARITY_MODE(P_PMODE[0]),
    .STOP_BITS(P_STOPS[0]), .START_LEVEL(1), .STOP_LEVEL(1), .ERR_DROP(P_DROP[0])) u_dut0 (
    .clk(clk), .arst_n(arst_n), .in(line[0]), .out_data(dout[0]), .out_valid(vld[0]),
    .out_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overflow(ovf[0]),
    .dbg_state(dbg[0]));

  serial_frame_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(P_CLKS[1]), .PARITY_MODE(P_PMODE[1]),
    .STOP_BITS(P_STOPS[1]), .START_LEVEL(1), .STOP_LEVEL(1), .ERR_DROP(P_DROP[1])) u_dut1 (
    .clk(clk), .arst_n(arst_n), .in(line[1]), .out_data(dout[1]), .out_valid(vld[1]),
    .out_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overflow(ovf[1]),
    .dbg_state(dbg[1]));

  serial_frame_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(P_CLKS[2]), .PARITY_MODE(P_PMODE[2]),
    .STOP_BITS(P_STOPS[2]), .START_LEVEL(1), .STOP_LEVEL(1), .ERR_DROP(P_DROP[2])) u_dut2 (
    .clk(clk), .arst_n(arst_n), .in(line[2]), .out_data(dout[2]), .out_valid(vld[2]),
    .out_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overflow(ovf[2]),
    .dbg_state(dbg[2]));

  serial_frame_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(P_CLKS[3]), .PARITY_MODE(P_PMODE[3]),
    .STOP_BITS(P_STOPS[3]), .START_LEVEL(1), .STOP_LEVEL(1), .ERR_DROP(P_DROP[3])) u_dut3 (
    .clk(clk), .arst_n(arst_n), .in(line[3]), .out_data(dout[3]), .out_valid(vld[3]),
    .out_ready(rdy[3]), .parity_err(pe[3]), .frame_err(fe[3]), .overflow(ovf[3]),
    .dbg_state(dbg[3]));

  // ---------------------------------------------------------------- checking
  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int d,
                              input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut=%0d got=%0h expected=%0h cycle=%0d", name, d, act, exp, cyc);
    end
  endfunction

  // Completed frames announced by the driver: a new sequence number means
  // "this frame completes on the coming clock edge".
  int           pend_seq  [N] = '{0, 0, 0, 0};
  logic [7:0]   pend_data [N];
  logic [N-1:0] pend_pe, pend_fe;

  // Model of the output register, updated on each clock edge.
  int           seen_seq [N] = '{0, 0, 0, 0};
  logic [N-1:0] m_valid = '0, m_pe = '0, m_fe = '0, m_ovf = '0;
  logic [7:0]   m_data [N] = '{8'h00, 8'h00, 8'h00, 8'h00};

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int d = 0; d < N; d++) begin
        m_valid[d]  = 1'b0;
        m_pe[d]     = 1'b0;
        m_fe[d]     = 1'b0;
        m_ovf[d]    = 1'b0;
        m_data[d]   = 8'h00;
        seen_seq[d] = pend_seq[d];
      end
    end else begin
      for (int d = 0; d < N; d++) begin
        logic acc;
        logic errored;
        acc = m_valid[d] && rdy[d];
        m_ovf[d] = 1'b0;
        if (acc) m_valid[d] = 1'b0;
        if (pend_seq[d] != seen_seq[d]) begin
          seen_seq[d] = pend_seq[d];
          errored = pend_pe[d] || pend_fe[d];
          if (!(P_DROP[d] != 0 && errored)) begin
            if (!m_valid[d]) begin
              m_valid[d] = 1'b1;
              m_data[d]  = pend_data[d];
              m_pe[d]    = pend_pe[d];
              m_fe[d]    = pend_fe[d];
            end else begin
              m_ovf[d] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Accepted frames as seen on the DUT ports, for the literal checks.
  typedef struct {
    int         d;
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } rec_t;
  rec_t acc_q[$];
  int   rise_cyc [N] = '{0, 0, 0, 0};
  int   vld_cnt  [N] = '{0, 0, 0, 0};
  int   ovf_cnt  [N] = '{0, 0, 0, 0};
  logic [N-1:0] prev_vld = '0;

  // Compare process: inputs change on negedge, so negedge+2 sees stable
  // outputs and the ready value that the next rising edge will use.
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < N; d++) begin
      if (!arst_n) begin
        chk("rst_valid", d, vld[d], 0);
        chk("rst_data", d, dout[d], 0);
        chk("rst_parity_err", d, pe[d], 0);
        chk("rst_frame_err", d, fe[d], 0);
        chk("rst_overflow", d, ovf[d], 0);
      end else begin
        chk("valid", d, vld[d], m_valid[d]);
        if (m_valid[d]) begin
          chk("data", d, dout[d], m_data[d]);
          chk("parity_err", d, pe[d], m_pe[d]);
          chk("frame_err", d, fe[d], m_fe[d]);
        end
        chk("overflow", d, ovf[d], m_ovf[d]);
        if (vld[d] && rdy[d]) acc_q.push_back('{d, dout[d], pe[d], fe[d]});
        if (vld[d] && !prev_vld[d]) rise_cyc[d] = cyc;
        if (vld[d]) vld_cnt[d]++;
        if (ovf[d]) ovf_cnt[d]++;
      end
      prev_vld[d] = vld[d];
    end
  end

  // ---------------------------------------------------------------- drivers
  int         start_cyc [N] = '{0, 0, 0, 0};
  logic [7:0] exp_q[$];
  logic [1:0] exp_f_q[$];
  int         log_base = 0;

  task automatic drive(input int d, input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      line[d] = v;
    end
  endtask

  // Sends one full frame; the line is left at the last stop level so a
  // following frame can start on the very next cycle.
  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic s1, input logic s2);
    int   c;
    logic last;
    logic xp;
    c = P_CLKS[d];
    @(negedge clk);
    line[d] = 1'b1;
    start_cyc[d] = cyc + 1;
    drive(d, 1'b1, c - 1);
    for (int i = 0; i < 8; i++) drive(d, data[i], c);
    if (P_PMODE[d] != 0) drive(d, pbit, c);
    if (P_STOPS[d] == 2) begin
      drive(d, s1, c);
      last = s2;
    end else begin
      last = s1;
    end
    drive(d, last, c - 1);
    @(negedge clk);
    line[d] = last;
    xp = (^data) ^ pbit;
    pend_data[d] = data;
    pend_pe[d]   = (P_PMODE[d] == 0) ? 1'b0 : ((P_PMODE[d] == 1) ? xp : ~xp);
    pend_fe[d]   = (s1 !== 1'b1) || ((P_STOPS[d] == 2) && (s2 !== 1'b1));
    pend_seq[d]  = pend_seq[d] + 1;
  endtask

  task automatic check_log(input string tag, input int d);
    int n;
    n = acc_q.size() - log_base;
    chk({tag, "_count"}, d, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({tag, "_dut"}, d, acc_q[log_base + i].d, d);
      chk({tag, "_data"}, d, acc_q[log_base + i].data, exp_q[i]);
      chk({tag, "_flags"}, d, {acc_q[log_base + i].pe, acc_q[log_base + i].fe}, exp_f_q[i]);
    end
    log_base = acc_q.size();
    exp_q.delete();
    exp_f_q.delete();
  endtask

  // ---------------------------------------------------------------- tests
  initial begin
    int         base;
    logic [7:0] d77;
    line   = '0;
    rdy    = '1;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5 clean frame; start at cycle 0, out_valid visible after edge 10.
    exp_q.push_back(8'hA5); exp_f_q.push_back(2'b00);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0, 6);
    chk("t1_latency", 0, rise_cyc[0] - start_cyc[0], 10);
    check_log("t1", 0);

    // Wrong even parity: delivered with parity_err.
    exp_q.push_back(8'hA5); exp_f_q.push_back(2'b10);
    send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1);
    drive(0, 1'b0, 6);
    check_log("t2a", 0);

    // ERR_DROP: parity and framing errors never show, a clean frame does.
    base = vld_cnt[1];
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    drive(1, 1'b0, 6);
    send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 6);
    chk("t2_drop_valid", 1, vld_cnt[1] - base, 0);
    exp_q.push_back(8'hA5); exp_f_q.push_back(2'b00);
    send_frame(1, 8'hA5, 1'b0, 1'b1, 1'b1);
    drive(1, 1'b0, 6);
    check_log("t2b", 1);

    // 16 clocks/bit: 3-cycle glitch is rejected, then a full 0x3C frame.
    base = vld_cnt[2];
    drive(2, 1'b1, 3);
    drive(2, 1'b0, 40);
    chk("t3_glitch_valid", 2, vld_cnt[2] - base, 0);
    chk("t3_glitch_idle", 2, dbg[2], 0);
    exp_q.push_back(8'h3C); exp_f_q.push_back(2'b00);
    send_frame(2, 8'h3C, 1'b0, 1'b1, 1'b1);
    drive(2, 1'b0, 20);
    check_log("t3", 2);

    // Two stop bits, back-to-back; second frame has a bad second stop bit.
    exp_q.push_back(8'h11); exp_f_q.push_back(2'b00);
    exp_q.push_back(8'h22); exp_f_q.push_back(2'b01);
    send_frame(3, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(3, 8'h22, 1'b0, 1'b1, 1'b0);
    drive(3, 1'b0, 6);
    check_log("t4", 3);

    // Overflow: consumer stalled across two frames.
    @(negedge clk);
    rdy[0] = 1'b0;
    base = ovf_cnt[0];
    send_frame(0, 8'h01, 1'b1, 1'b1, 1'b1);
    send_frame(0, 8'h02, 1'b1, 1'b1, 1'b1);
    drive(0, 1'b0, 5);
    chk("t5_hold_valid", 0, vld[0], 1);
    chk("t5_hold_data", 0, dout[0], 8'h01);
    chk("t5_ovf_pulses", 0, ovf_cnt[0] - base, 1);
    chk("t5_no_accept", 0, acc_q.size() - log_base, 0);
    @(negedge clk);
    rdy[0] = 1'b1;
    exp_q.push_back(8'h01); exp_f_q.push_back(2'b00);
    drive(0, 1'b0, 3);
    chk("t5_valid_fell", 0, vld[0], 0);
    check_log("t5", 0);

    // Reset during data bit 4 of 0x77, then a clean 0x5A.
    d77 = 8'h77;
    drive(0, 1'b1, 1);
    for (int i = 0; i < 4; i++) drive(0, d77[i], 1);
    @(negedge clk);
    arst_n  = 1'b0;
    line[0] = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("t6_rst_valid", 0, vld[0], 0);
    chk("t6_rst_state", 0, dbg[0], 0);
    @(negedge clk);
    arst_n = 1'b1;
    drive(0, 1'b0, 4);
    exp_q.push_back(8'h5A); exp_f_q.push_back(2'b00);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0, 6);
    check_log("t6", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
